// File: rtl/fir_bist.sv
// Self-test sequencer for the FIR datapath: flushes the filter, plays a stimulus
// table into Xn and checks Yn against an expected-response table.
module fir_bist #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned HOLD      = 3,
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  input  logic [WIDTH-1:0]  Yn,
  output logic [WIDTH-1:0]  Xn,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [ADDR_W-1:0] sample_idx
);

  localparam int unsigned HoldW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned FlushW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD - 1);
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYC - 1);
  localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthLim  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFlush, StDrive, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  stim_q [DEPTH];
  logic [WIDTH-1:0]  exp_q  [DEPTH];
  logic [WIDTH-1:0]  xn_q;
  logic [CNT_W-1:0]  fail_count_q;
  logic [ADDR_W-1:0] first_fail_idx_q;
  logic [ADDR_W-1:0] sample_idx_q;
  logic [HoldW-1:0]  hold_q;
  logic [FlushW-1:0] flush_q;

  logic              wr_ok;
  logic              cmp_cycle;
  logic              mismatch;
  logic              last_idx;
  logic [ADDR_W-1:0] next_idx;

  // Decode of the compare slot and table write qualification
  always_comb begin
    wr_ok     = load_en && !busy && ({1'b0, load_addr} < DepthLim);
    cmp_cycle = (state_q == StDrive) && (hold_q == HoldLast);
    mismatch  = cmp_cycle && (Yn != exp_q[sample_idx_q]);
    last_idx  = (sample_idx_q == LastIdx);
    next_idx  = sample_idx_q + ADDR_W'(1);
  end

  // Table storage; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (load_sel) exp_q[load_addr]  <= load_data;
      else          stim_q[load_addr] <= load_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!arst_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StFlush;
      StFlush:        if (flush_q == '0) state_d = StDrive;
      StDrive:        if (cmp_cycle && last_idx) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q == StFlush) || (state_q == StDrive);
    done = (state_q == StDone);
    pass = done && (fail_count_q == '0);
  end

  // Sample driver, counters and mismatch bookkeeping
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      xn_q             <= '0;
      fail_count_q     <= '0;
      first_fail_idx_q <= '0;
      sample_idx_q     <= '0;
      hold_q           <= '0;
      flush_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          xn_q <= '0;
          if (start) begin
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            sample_idx_q     <= '0;
            hold_q           <= '0;
            flush_q          <= FlushLoad;
          end
        end
        StFlush: begin
          xn_q <= '0;
          if (flush_q == '0) begin
            // Table read happens here, so a write in the start cycle is seen
            xn_q         <= stim_q[0];
            sample_idx_q <= '0;
            hold_q       <= '0;
          end else begin
            flush_q <= flush_q - FlushW'(1);
          end
        end
        StDrive: begin
          if (cmp_cycle) begin
            if (mismatch) begin
              if (fail_count_q == '0)  first_fail_idx_q <= sample_idx_q;
              if (fail_count_q != '1) fail_count_q     <= fail_count_q + CNT_W'(1);
            end
            if (last_idx) begin
              xn_q <= '0;
            end else begin
              xn_q         <= stim_q[next_idx];
              sample_idx_q <= next_idx;
              hold_q       <= '0;
            end
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        default: xn_q <= '0;
      endcase
    end
  end

  assign Xn             = xn_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;
  assign sample_idx     = sample_idx_q;

endmodule

// File: doc/fir_bist.md
Name: fir_bist

Overview:
- Hardware self-test sequencer for the FIR datapath. It is the driving and checking end of the FIR Xn/Yn sample interface.
- It holds a stimulus table and an expected-response table, loaded through a write port.
- After start, it flushes the FIR, plays the stimulus into Xn with a fixed hold per sample, and compares Yn against the expected table.
- It reports pass/fail, a mismatch count and the first failing index. It sits beside the FIR instance for on-chip regression.

Parameters:
- WIDTH, 16, sample width of Xn/Yn, signed two's complement
- DEPTH, 10, number of stimulus/expected entries
- ADDR_W, 4, table address width; must satisfy 2**ADDR_W >= DEPTH
- HOLD, 3, cycles each sample is held on Xn before Yn is compared (NUM_TAPS-1)
- FLUSH_CYC, 4, cycles of Xn=0 driven before the first sample (NUM_TAPS)
- CNT_W, 8, width of fail_count

Ports:
- clk  input  1  system clock, rising edge
- arst_n  input  1  reset, synchronous, active-low (sampled on rising clk)
- load_en  input  1  table write strobe; honoured only while not busy
- load_sel  input  1  0 = stimulus table, 1 = expected table
- load_addr  input  ADDR_W  table write address; writes with load_addr >= DEPTH are ignored
- load_data  input  WIDTH  signed table write data
- start  input  1  one-cycle pulse that begins a run; ignored while busy
- Yn  input  WIDTH  signed FIR output (registered in the FIR)
- Xn  output  WIDTH  signed sample driven to the FIR
- busy  output  1  high in FLUSH and DRIVE
- done  output  1  high in DONE; cleared by the next accepted start
- pass  output  1  valid while done; 1 iff fail_count==0
- fail_count  output  CNT_W  number of mismatches; saturates at all-ones
- first_fail_idx  output  ADDR_W  index of the first mismatch; 0 if none
- sample_idx  output  ADDR_W  index currently driven

Behaviour:
- Reset (arst_n=0 at a rising edge):
  - state=IDLE.
  - Xn, fail_count, first_fail_idx, sample_idx, hold counter and flush counter all go to 0.
  - busy, done and pass go to 0.
  - Table contents are not reset.
- Reset mid-run aborts the run immediately, with no done pulse.
- States:
  - IDLE: Xn=0. An accepted start moves to FLUSH, clears fail_count/first_fail_idx/sample_idx/done/pass, and loads the flush counter with FLUSH_CYC-1.
  - FLUSH: Xn=0 for exactly FLUSH_CYC cycles. Then go to DRIVE with sample_idx=0 and hold counter=0.
  - DRIVE:
    - Xn = stim[sample_idx], registered, so Xn updates on the edge that enters a new index.
    - Hold counter runs 0..HOLD-1.
    - In the cycle where hold counter==HOLD-1, compare Yn with exp[sample_idx] as a full-width signed compare. On mismatch: fail_count++ (saturating); if this is the first mismatch, first_fail_idx=sample_idx.
    - Still in that cycle: if sample_idx==DEPTH-1, go to DONE; otherwise increment sample_idx and reset the hold counter.
  - DONE:
    - Xn=0.
    - done=1, pass=(fail_count==0), including a mismatch found on the final compare cycle.
    - Stays in DONE until the next start, which behaves as start from IDLE.
- Total run length: FLUSH_CYC + DEPTH*HOLD cycles from the first FLUSH cycle to the first DONE cycle.
- Table writes:
  - Accepted in IDLE/DONE on rising clk when load_en=1.
  - Ignored in FLUSH/DRIVE.
  - Ignored if load_addr >= DEPTH.
- start with load_en in the same cycle: the write is accepted and the run starts. The first stimulus is read no earlier than FLUSH_CYC cycles later, so the new data is used.
- start while busy: ignored, with no effect on counters.
- HOLD=1: a compare occurs every DRIVE cycle. FLUSH_CYC=0 is not supported (minimum 1).
- Tables are plain register arrays, WIDTH x DEPTH each, with asynchronous read.

Test Plan:
- Reset: assert arst_n=0 for 2 cycles mid-DRIVE → busy=0, done=0, Xn=0, fail_count=0 on the following cycle; a subsequent start performs a full run.
- Identity FIR (Yn fed back as a registered Xn with matching delay), stim = 0x0001..0x000A, exp = same values → done after 4+10*3=34 cycles, pass=1, fail_count=0.
- Single corrupted entry: exp[6] = 0x7FFF, all other entries matching → pass=0, fail_count=1, first_fail_idx=6.
- Two mismatches at indices 2 and 9 (9 is the last compare) → fail_count=2, first_fail_idx=2, pass=0 visible in the first DONE cycle.
- Negative samples: stim/exp containing 0x8000 and 0xFFFF → compares match without sign errors; pass=1.
- Protocol abuse:
  - start pulsed during FLUSH and DRIVE → ignored; run length stays 34 cycles.
  - load_en during DRIVE → table unchanged (verify by re-run).
  - load_addr = 12 → ignored.
  - Tie Yn to 0x0005 with CNT_W=2 and all exp ≠ 5 → fail_count saturates at 3.
